irq_seq_ctrl: RTL and testbench

//  Interrupt/reset micro-sequencer for the 2A03 core, generalising the

---
 rtl/irq_seq_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_irq_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_seq_ctrl.sv
// irq_seq_ctrl: RESET/NMI/IRQ/BRK entry micro-sequencer for the 2A03 core.
// Owns the bus for the 7-cycle entry sequence; the main control FSM stalls while busy=1.
module irq_seq_ctrl #(
    parameter int          N_IRQ    = 1,
    parameter int          ADDR_W   = 16,
    parameter logic [7:0]  STACK_PG = 8'h01,
    parameter logic [15:0] VEC_NMI  = 16'hFFFA,
    parameter logic [15:0] VEC_RST  = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ  = 16'hFFFE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              nmi_n,
    input  logic [N_IRQ-1:0]  irq_n,
    input  logic              p_i,
    input  logic              brk,
    input  logic              boundary,
    input  logic [15:0]       pc,
    input  logic [7:0]        p_in,
    input  logic [7:0]        s_in,
    input  logic [7:0]        din,
    output logic              busy,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        dout,
    output logic              mem_rw,
    output logic              s_dec,
    output logic              pcl_ld,
    output logic              pch_ld,
    output logic              pi_set
);

    typedef enum logic [2:0] {
        S_IDLE, S_D1, S_D2, S_PSH_H, S_PSH_L, S_PSH_P, S_VEC_L, S_VEC_H
    } state_e;

    typedef enum logic [1:0] {K_RST, K_NMI, K_IRQ, K_BRK} kind_e;

    state_e            state_q, state_d;
    kind_e             kind_q, kind_d;
    logic              nmi_pend_q, nmi_pend_d;
    logic              nmi_prev_q, nmi_prev_d;
    logic              busy_q, busy_d;
    logic              mem_rw_q, mem_rw_d;
    logic              s_dec_q, s_dec_d;
    logic              pcl_ld_q, pcl_ld_d;
    logic              pch_ld_q, pch_ld_d;
    logic              pi_set_q, pi_set_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        dout_q, dout_d;

    logic              irq_req;
    logic              nmi_edge;
    logic [7:0]        s_cur;
    logic [15:0]       addr16;
    logic              unused_p_bits;

    assign irq_req       = (|(~irq_n)) & ~p_i;
    assign nmi_edge      = nmi_prev_q & ~nmi_n;
    assign unused_p_bits = ^p_in[5:4];

    // Outputs are registered one cycle ahead, so while a push is in flight
    // the core's S decrement lands on the same edge we compute the next address.
    assign s_cur = s_dec_q ? (s_in - 8'd1) : s_in;

    function automatic logic [15:0] vec_of(input kind_e k);
        case (k)
            K_NMI:   return VEC_NMI;
            K_RST:   return VEC_RST;
            default: return VEC_IRQ;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        nmi_prev_d = nmi_n;
        nmi_pend_d = nmi_pend_q | nmi_edge;

        case (state_q)
            S_IDLE: begin
                if (brk) begin
                    kind_d  = K_BRK;
                    state_d = S_D1;
                end else if (boundary && nmi_pend_q) begin
                    kind_d  = K_NMI;
                    state_d = S_D1;
                end else if (boundary && irq_req) begin
                    kind_d  = K_IRQ;
                    state_d = S_D1;
                end
            end
            S_D1:    state_d = S_D2;
            S_D2:    state_d = S_PSH_H;
            S_PSH_H: state_d = S_PSH_L;
            S_PSH_L: state_d = S_PSH_P;
            S_PSH_P: begin
                state_d = S_VEC_L;
                // Late NMI hijacks the vector; the B bit already pushed stays as is.
                if (nmi_pend_q && (kind_q == K_IRQ || kind_q == K_BRK))
                    kind_d = K_NMI;
            end
            S_VEC_L: begin
                state_d = S_VEC_H;
                if (kind_q == K_NMI)
                    nmi_pend_d = nmi_edge;
            end
            S_VEC_H: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d   = (state_d != S_IDLE);
        mem_rw_d = 1'b1;
        s_dec_d  = 1'b0;
        pcl_ld_d = 1'b0;
        pch_ld_d = 1'b0;
        pi_set_d = 1'b0;
        addr16   = 16'h0000;
        dout_d   = 8'h00;

        case (state_d)
            S_D1, S_D2: addr16 = pc;
            S_PSH_H, S_PSH_L, S_PSH_P: begin
                addr16   = {STACK_PG, s_cur};
                s_dec_d  = 1'b1;
                mem_rw_d = (kind_d == K_RST);
                case (state_d)
                    S_PSH_H: dout_d = pc[15:8];
                    S_PSH_L: dout_d = pc[7:0];
                    default: dout_d = {p_in[7:6], 1'b1, (kind_d == K_BRK), p_in[3:0]};
                endcase
            end
            S_VEC_L: begin
                addr16   = vec_of(kind_d);
                pcl_ld_d = 1'b1;
                pi_set_d = 1'b1;
            end
            S_VEC_H: begin
                addr16   = vec_of(kind_d) + 16'd1;
                pch_ld_d = 1'b1;
            end
            default: addr16 = 16'h0000;
        endcase

        addr_d = addr16[ADDR_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_D1;
            kind_q     <= K_RST;
            nmi_pend_q <= 1'b0;
            nmi_prev_q <= 1'b1;
            busy_q     <= 1'b1;
            mem_rw_q   <= 1'b1;
            s_dec_q    <= 1'b0;
            pcl_ld_q   <= 1'b0;
            pch_ld_q   <= 1'b0;
            pi_set_q   <= 1'b0;
            addr_q     <= '0;
            dout_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            nmi_pend_q <= nmi_pend_d;
            nmi_prev_q <= nmi_prev_d;
            busy_q     <= busy_d;
            mem_rw_q   <= mem_rw_d;
            s_dec_q    <= s_dec_d;
            pcl_ld_q   <= pcl_ld_d;
            pch_ld_q   <= pch_ld_d;
            pi_set_q   <= pi_set_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
        end
    end

    assign busy   = busy_q;
    assign addr   = addr_q;
    assign dout   = dout_q;
    assign mem_rw = mem_rw_q;
    assign s_dec  = s_dec_q;
    assign pcl_ld = pcl_ld_q;
    assign pch_ld = pch_ld_q;
    assign pi_set = pi_set_q;

endmodule

// File: tb/tb_irq_seq_ctrl.sv
// Bench for irq_seq_ctrl: table of per-cycle vectors plus hand sequences
// for masking, NMI edge detection and reset abort.
module tb_irq_seq_ctrl;
    localparam int N_IRQ = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             nmi_n = 1'b1;
    logic [N_IRQ-1:0] irq_n = '1;
    logic             p_i = 1'b0;
    logic             brk = 1'b0;
    logic             boundary = 1'b0;
    logic [15:0]      pc = 16'h0000;
    logic [7:0]       p_in = 8'h02;
    logic [7:0]       s_in;
    logic [7:0]       din = 8'h00;
    logic             busy, mem_rw, s_dec, pcl_ld, pch_ld, pi_set;
    logic [15:0]      addr;
    logic [7:0]       dout;

    irq_seq_ctrl #(.N_IRQ(N_IRQ)) dut (
        .clk(clk), .rst_n(rst_n), .nmi_n(nmi_n), .irq_n(irq_n), .p_i(p_i),
        .brk(brk), .boundary(boundary), .pc(pc), .p_in(p_in), .s_in(s_in),
        .din(din), .busy(busy), .addr(addr), .dout(dout), .mem_rw(mem_rw),
        .s_dec(s_dec), .pcl_ld(pcl_ld), .pch_ld(pch_ld), .pi_set(pi_set)
    );

    always #5 clk = ~clk;

    // CPU-side model: stack pointer and program counter react to the strobes.
    logic [7:0]  s_base = 8'h00;
    logic [7:0]  dec_total = 8'h00;
    logic [15:0] ld_pc = 16'h0000;
    assign s_in = s_base - dec_total;

    always @(posedge clk) begin
        if (s_dec) dec_total <= dec_total + 8'd1;
        if (pcl_ld) ld_pc[7:0] <= din;
        if (pch_ld) ld_pc[15:8] <= din;
    end

    int          busy_tot = 0, wr_tot = 0, sdec_tot = 0, pcl_tot = 0;
    logic [15:0] last_vec = 16'h0000;
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_tot <= busy_tot + 1;
            if (busy && !mem_rw) wr_tot <= wr_tot + 1;
            if (s_dec) sdec_tot <= sdec_tot + 1;
            if (pcl_ld) begin
                pcl_tot  <= pcl_tot + 1;
                last_vec <= addr;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    localparam logic [29:0] M_ALL  = 30'h3FFFFFFF;
    localparam logic [29:0] M_RD   = 30'h3FFFFF00;
    localparam logic [29:0] M_IDLE = 30'h2F000000;

    function automatic logic [29:0] pk(input logic b, rw, sd, pl, ph, ps,
                                       input logic [15:0] a, input logic [7:0] d);
        return {b, rw, sd, pl, ph, ps, a, d};
    endfunction

    function automatic logic [29:0] cur_out();
        return {busy, mem_rw, s_dec, pcl_ld, pch_ld, pi_set, addr, dout};
    endfunction

    task automatic chk(input string nm, input logic [29:0] act, exp, mask);
        checks++;
        if ((act & mask) !== (exp & mask)) begin
            errors++;
            $display("FAIL %s: got %h expected %h (mask %h)", nm, act & mask, exp & mask, mask);
        end
    endtask

    task automatic chk_int(input string nm, input int act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        string            name;
        logic [N_IRQ-1:0] irq_n;
        logic             brk, bnd, nmi_n, p_i;
        logic [15:0]      pc;
        logic [7:0]       din;
        logic [29:0]      exp, mask;
    } row_t;

    row_t rows[$];

    function automatic row_t mk(input string nm, input logic [N_IRQ-1:0] in_irq,
                                input logic in_brk, in_bnd, in_nmi, in_pi,
                                input logic [15:0] in_pc, input logic [7:0] in_din,
                                input logic [29:0] e, m);
        row_t r;
        r.name = nm; r.irq_n = in_irq; r.brk = in_brk; r.bnd = in_bnd;
        r.nmi_n = in_nmi; r.p_i = in_pi; r.pc = in_pc; r.din = in_din;
        r.exp = e; r.mask = m;
        return r;
    endfunction

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            irq_n = rows[i].irq_n; brk = rows[i].brk; boundary = rows[i].bnd;
            nmi_n = rows[i].nmi_n; p_i = rows[i].p_i; pc = rows[i].pc; din = rows[i].din;
            @(posedge clk); #1;
            chk(rows[i].name, cur_out(), rows[i].exp, rows[i].mask);
        end
        brk = 1'b0; boundary = 1'b0;
    endtask

    task automatic set_s(input logic [7:0] v);
        s_base = v + dec_total;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1 while rst_n is low; releases reset and checks the full sequence.
    task automatic reset_release_seq(input string tag);
        int b0, w0, d0;
        set_s(8'hFD);
        b0 = busy_tot; w0 = wr_tot; d0 = sdec_tot;
        rst_n = 1'b1;
        chk({tag, "_d1"}, cur_out(), pk(1, 1, 0, 0, 0, 0, 16'h0000, 8'h00), M_ALL);
        run_rows(0, 6);
        step(1);
        chk_int({tag, "_busy_cycles"}, busy_tot - b0, 7);
        chk_int({tag, "_writes"}, wr_tot - w0, 0);
        chk_int({tag, "_s_dec"}, sdec_tot - d0, 3);
        chk_int({tag, "_pc"}, int'(ld_pc), 32'h8000);
    endtask

    initial begin
        int b0, p0;

        // Reset sequence rows 0..6
        rows.push_back(mk("rst_d2",    2'b11, 0, 0, 1, 0, 16'h0000, 8'h00, pk(1, 1, 0, 0, 0, 0, 16'h0000, 8'h00), M_RD));
        rows.push_back(mk("rst_psh_h", 2'b11, 0, 0, 1, 0, 16'h0000, 8'h00, pk(1, 1, 1, 0, 0, 0, 16'h01FD, 8'h00), M_RD));
        rows.push_back(mk("rst_psh_l", 2'b11, 0, 0, 1, 0, 16'h0000, 8'h00, pk(1, 1, 1, 0, 0, 0, 16'h01FC, 8'h00), M_RD));
        rows.push_back(mk("rst_psh_p", 2'b11, 0, 0, 1, 0, 16'h0000, 8'h00, pk(1, 1, 1, 0, 0, 0, 16'h01FB, 8'h00), M_RD));
        rows.push_back(mk("rst_vec_l", 2'b11, 0, 0, 1, 0, 16'h0000, 8'h00, pk(1, 1, 0, 1, 0, 1, 16'hFFFC, 8'h00), M_RD));
        rows.push_back(mk("rst_vec_h", 2'b11, 0, 0, 1, 0, 16'h0000, 8'h00, pk(1, 1, 0, 0, 1, 0, 16'hFFFD, 8'h00), M_RD));
        rows.push_back(mk("rst_idle",  2'b11, 0, 0, 1, 0, 16'h0000, 8'h80, pk(0, 1, 0, 0, 0, 0, 16'h0000, 8'h00), M_IDLE));
        // IRQ rows 7..14 (line released mid-sequence must not abort)
        rows.push_back(mk("irq_d1",    2'b10, 0, 1, 1, 0, 16'h1234, 8'h00, pk(1, 1, 0, 0, 0, 0, 16'h1234, 8'h00), M_RD));
        rows.push_back(mk("irq_d2",    2'b10, 0, 0, 1, 0, 16'h1234, 8'h00, pk(1, 1, 0, 0, 0, 0, 16'h1234, 8'h00), M_RD));
        rows.push_back(mk("irq_psh_h", 2'b11, 0, 0, 1, 0, 16'h1234, 8'h00, pk(1, 0, 1, 0, 0, 0, 16'h01FD, 8'h12), M_ALL));
        rows.push_back(mk("irq_psh_l", 2'b11, 0, 0, 1, 0, 16'h1234, 8'h00, pk(1, 0, 1, 0, 0, 0, 16'h01FC, 8'h34), M_ALL));
        rows.push_back(mk("irq_psh_p", 2'b11, 0, 0, 1, 0, 16'h1234, 8'h00, pk(1, 0, 1, 0, 0, 0, 16'h01FB, 8'h22), M_ALL));
        rows.push_back(mk("irq_vec_l", 2'b11, 0, 0, 1, 0, 16'h1234, 8'h00, pk(1, 1, 0, 1, 0, 1, 16'hFFFE, 8'h00), M_RD));
        rows.push_back(mk("irq_vec_h", 2'b11, 0, 0, 1, 0, 16'h1234, 8'h56, pk(1, 1, 0, 0, 1, 0, 16'hFFFF, 8'h00), M_RD));
        rows.push_back(mk("irq_idle",  2'b11, 0, 0, 1, 0, 16'h1234, 8'h78, pk(0, 1, 0, 0, 0, 0, 16'h0000, 8'h00), M_IDLE));
        // BRK with NMI falling during PSH_L, rows 15..23
        rows.push_back(mk("brk_d1",    2'b11, 1, 0, 1, 1, 16'h0202, 8'h00, pk(1, 1, 0, 0, 0, 0, 16'h0202, 8'h00), M_RD));
        rows.push_back(mk("brk_d2",    2'b11, 0, 0, 1, 1, 16'h0202, 8'h00, pk(1, 1, 0, 0, 0, 0, 16'h0202, 8'h00), M_RD));
        rows.push_back(mk("brk_psh_h", 2'b11, 0, 0, 1, 1, 16'h0202, 8'h00, pk(1, 0, 1, 0, 0, 0, 16'h01FD, 8'h02), M_ALL));
        rows.push_back(mk("brk_psh_l", 2'b11, 0, 0, 1, 1, 16'h0202, 8'h00, pk(1, 0, 1, 0, 0, 0, 16'h01FC, 8'h02), M_ALL));
        rows.push_back(mk("brk_psh_p", 2'b11, 0, 0, 0, 1, 16'h0202, 8'h00, pk(1, 0, 1, 0, 0, 0, 16'h01FB, 8'h32), M_ALL));
        rows.push_back(mk("brk_vec_l", 2'b11, 0, 0, 0, 1, 16'h0202, 8'h00, pk(1, 1, 0, 1, 0, 1, 16'hFFFA, 8'h00), M_RD));
        rows.push_back(mk("brk_vec_h", 2'b11, 0, 0, 1, 1, 16'h0202, 8'h00, pk(1, 1, 0, 0, 1, 0, 16'hFFFB, 8'h00), M_RD));
        rows.push_back(mk("brk_idle",  2'b11, 0, 0, 1, 1, 16'h0202, 8'h00, pk(0, 1, 0, 0, 0, 0, 16'h0000, 8'h00), M_IDLE));
        rows.push_back(mk("brk_no_pend", 2'b11, 0, 1, 1, 1, 16'h0202, 8'h00, pk(0, 1, 0, 0, 0, 0, 16'h0000, 8'h00), M_IDLE));

        // Power-on reset
        rst_n = 1'b0;
        step(3);
        chk("rst_hold", cur_out(), pk(1, 1, 0, 0, 0, 0, 16'h0000, 8'h00), M_ALL);
        reset_release_seq("rst");

        // IRQ entry
        set_s(8'hFD);
        run_rows(7, 14);
        step(1);
        chk_int("irq_pc", int'(ld_pc), 32'h7856);

        // BRK with NMI hijack
        set_s(8'hFD);
        run_rows(15, 23);

        // Masked IRQ
        p_i = 1'b1; irq_n = '0; b0 = busy_tot;
        for (int c = 0; c < 20; c++) begin
            boundary = (c % 2 == 0);
            step(1);
        end
        boundary = 1'b0;
        step(1);
        chk_int("masked_busy", busy_tot - b0, 0);

        // NMI edge: one long low level gives one sequence
        irq_n = '1; b0 = busy_tot; p0 = pcl_tot; set_s(8'hFD);
        for (int c = 0; c < 50; c++) begin
            nmi_n = 1'b0;
            boundary = (c == 5 || c == 30);
            step(1);
        end
        boundary = 1'b0; nmi_n = 1'b1;
        step(10);
        chk_int("nmi_one_seq", pcl_tot - p0, 1);
        chk_int("nmi_busy", busy_tot - b0, 7);
        chk_int("nmi_vec", int'(last_vec), 32'hFFFA);
        for (int c = 0; c < 3; c++) begin
            nmi_n = 1'b0;
            boundary = (c == 2);
            step(1);
        end
        boundary = 1'b0;
        step(10);
        chk_int("nmi_second_seq", pcl_tot - p0, 2);
        chk_int("nmi_busy2", busy_tot - b0, 14);
        nmi_n = 1'b1;
        step(2);

        // Reset abort during PSH_P of an IRQ
        set_s(8'hFD);
        p_i = 1'b0; irq_n = 2'b10; pc = 16'h1234; boundary = 1'b1;
        step(1);
        boundary = 1'b0;
        step(4);
        chk("abort_psh_p", cur_out(), pk(1, 0, 1, 0, 0, 0, 16'h01FB, 8'h22), M_ALL);
        #2 rst_n = 1'b0;
        #1 chk("abort_immediate", cur_out(), pk(1, 1, 0, 0, 0, 0, 16'h0000, 8'h00), M_ALL);
        irq_n = '1;
        step(2);
        reset_release_seq("abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
